// File: rtl/ycbcr_pkg.sv
// Shared constants for the YCbCr to RGB pipeline: mode encodings, coefficient table,
// stage count and range offsets.
package ycbcr_pkg;

  // Register stages from input sample to RGB output.
  localparam int unsigned NUM_STAGES = 4;

  // Coefficient table entries are Q2.10 magnitudes.
  localparam int unsigned COEF_FRAC_W = 10;
  localparam int unsigned COEF_W      = 12;

  // Limited-range luma gain, 255/219 in Q.10.
  localparam int unsigned Y_LIM_GAIN = 1192;

  // Offsets at 8-bit scale; shifted up for wider components.
  localparam int unsigned CHROMA_MID = 128;
  localparam int unsigned LUMA_BLACK = 16;

  // Bit 0 selects the standard, bit 1 selects the range.
  typedef enum logic [1:0] {
    Mode601Full = 2'b00,
    Mode709Full = 2'b01,
    Mode601Lim  = 2'b10,
    Mode709Lim  = 2'b11
  } mode_e;

  // R = Y + r_cr*Cr, G = Y - g_cb*Cb - g_cr*Cr, B = Y + b_cb*Cb
  typedef struct packed {
    logic [COEF_W-1:0] r_cr;
    logic [COEF_W-1:0] g_cb;
    logic [COEF_W-1:0] g_cr;
    logic [COEF_W-1:0] b_cb;
  } coef_t;

  function automatic coef_t coef_lookup(input mode_e mode);
    coef_t c;
    case (mode)
      Mode709Full: c = '{r_cr: 12'd1613, g_cb: 12'd192, g_cr: 12'd479, b_cb: 12'd1900};
      Mode601Lim:  c = '{r_cr: 12'd1634, g_cb: 12'd401, g_cr: 12'd833, b_cb: 12'd2066};
      Mode709Lim:  c = '{r_cr: 12'd1836, g_cb: 12'd218, g_cr: 12'd546, b_cb: 12'd2163};
      default:     c = '{r_cr: 12'd1436, g_cb: 12'd352, g_cr: 12'd731, b_cb: 12'd1815};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ycc_clamp.sv
// One output channel: round half up, drop the fraction bits, saturate to [0, 2^DATA_W-1].
module ycc_clamp #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC_W = 10,
  parameter int unsigned SUM_W  = 32
) (
  input  logic signed [SUM_W-1:0]  sum_i,
  output logic        [DATA_W-1:0] pix_o
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam int unsigned RW = SUM_W + 1;
  localparam logic signed [RW-1:0] HALF    = RW'(1) <<< (FRAC_W - 1);
  localparam logic signed [RW-1:0] MAX_PIX = RW'((1 << DATA_W) - 1);

  logic signed [RW-1:0] rnd;

  assign rnd = (RW'(sum_i) + HALF) >>> FRAC_W;

  // Saturate the rounded integer into the output range.
  always_comb begin
    pix_o = rnd[DATA_W-1:0];
    if (rnd[RW-1]) begin
      pix_o = '0;
    end else if (rnd > MAX_PIX) begin
      pix_o = '1;
    end
  end

endmodule

// File: rtl/ycbcr2rgb_pipe.sv
// Four-stage YCbCr to RGB converter: offset, multiply, sum, round/clamp.
// Selectable BT.601/BT.709 and full/limited range; mode changes only on frame start.
module ycbcr2rgb_pipe
  import ycbcr_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC_W = 10
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_mode,
  input  logic              i_vs,
  input  logic              i_hs,
  input  logic              i_convert_en,
  input  logic [DATA_W-1:0] i_y_data,
  input  logic [DATA_W-1:0] i_cb_data,
  input  logic [DATA_W-1:0] i_cr_data,
  output logic              o_vs,
  output logic              o_hs,
  output logic              o_convert_en,
  output logic [DATA_W-1:0] o_red,
  output logic [DATA_W-1:0] o_green,
  output logic [DATA_W-1:0] o_blue,
  output logic [1:0]        o_mode_active
);

  localparam int unsigned YW     = DATA_W + 2;  // offset components, signed
  localparam int unsigned CW     = FRAC_W + 3;  // scaled coefficients, signed
  localparam int unsigned PW     = YW + CW;     // products
  localparam int unsigned SW     = PW + 2;      // three-term sums
  localparam int unsigned CSHIFT = FRAC_W - COEF_FRAC_W;

  localparam logic signed [YW-1:0] C_OFS  = YW'(CHROMA_MID << (DATA_W - 8));
  localparam logic signed [YW-1:0] K_OFS  = YW'(LUMA_BLACK << (DATA_W - 8));
  localparam logic signed [CW-1:0] Y_GAIN = CW'(Y_LIM_GAIN);

  // Control state
  logic                  vs_prev_q;
  logic [1:0]            mode_active_q;
  logic [1:0]            mode_sel;
  logic [NUM_STAGES-1:0] vs_dly_q, hs_dly_q, en_dly_q;

  // Datapath state
  logic [1:0]            s1_mode_q;
  logic signed [YW-1:0]  s1_y_q, s1_cb_q, s1_cr_q;
  logic signed [PW-1:0]  s2_y_q, s2_rcr_q, s2_gcb_q, s2_gcr_q, s2_bcb_q;
  logic signed [SW-1:0]  s3_r_q, s3_g_q, s3_b_q;

  logic signed [YW-1:0]  y_in, cb_in, cr_in;
  coef_t                 cf;
  logic signed [CW-1:0]  k_rcr, k_gcb, k_gcr, k_bcb;
  logic [DATA_W-1:0]     red_c, green_c, blue_c;

  // A frame-start pixel already uses the mode latched on that same edge.
  assign mode_sel = (i_vs && !vs_prev_q) ? i_mode : mode_active_q;

  assign y_in  = signed'({2'b00, i_y_data});
  assign cb_in = signed'({2'b00, i_cb_data});
  assign cr_in = signed'({2'b00, i_cr_data});

  // Coefficients follow the mode carried by the pixel, not the live mode register.
  assign cf    = coef_lookup(mode_e'(s1_mode_q));
  assign k_rcr = CW'(cf.r_cr) << CSHIFT;
  assign k_gcb = CW'(cf.g_cb) << CSHIFT;
  assign k_gcr = CW'(cf.g_cr) << CSHIFT;
  assign k_bcb = CW'(cf.b_cb) << CSHIFT;

  // Mode latch, sync/valid delay lines and held RGB outputs.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      vs_prev_q     <= 1'b0;
      mode_active_q <= 2'b00;
      vs_dly_q      <= '0;
      hs_dly_q      <= '0;
      en_dly_q      <= '0;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
    end else begin
      vs_prev_q     <= i_vs;
      mode_active_q <= mode_sel;
      vs_dly_q      <= {vs_dly_q[NUM_STAGES-2:0], i_vs};
      hs_dly_q      <= {hs_dly_q[NUM_STAGES-2:0], i_hs};
      en_dly_q      <= {en_dly_q[NUM_STAGES-2:0], i_convert_en};
      if (en_dly_q[NUM_STAGES-2]) begin
        o_red   <= red_c;
        o_green <= green_c;
        o_blue  <= blue_c;
      end
    end
  end

  // Offset, multiply and sum stages; validity is tracked by en_dly_q.
  always_ff @(posedge i_sys_clk) begin
    s1_mode_q <= mode_sel;
    s1_y_q    <= mode_sel[1] ? (y_in - K_OFS) : y_in;
    s1_cb_q   <= cb_in - C_OFS;
    s1_cr_q   <= cr_in - C_OFS;

    s2_y_q    <= s1_mode_q[1] ? ((PW'(s1_y_q) * PW'(Y_GAIN)) <<< CSHIFT)
                              : (PW'(s1_y_q) <<< FRAC_W);
    s2_rcr_q  <= PW'(k_rcr) * PW'(s1_cr_q);
    s2_gcb_q  <= PW'(k_gcb) * PW'(s1_cb_q);
    s2_gcr_q  <= PW'(k_gcr) * PW'(s1_cr_q);
    s2_bcb_q  <= PW'(k_bcb) * PW'(s1_cb_q);

    s3_r_q    <= SW'(s2_y_q) + SW'(s2_rcr_q);
    s3_g_q    <= SW'(s2_y_q) - SW'(s2_gcb_q) - SW'(s2_gcr_q);
    s3_b_q    <= SW'(s2_y_q) + SW'(s2_bcb_q);
  end

  ycc_clamp #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SUM_W(SW)) u_clamp_r (
    .sum_i (s3_r_q),
    .pix_o (red_c)
  );

  ycc_clamp #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SUM_W(SW)) u_clamp_g (
    .sum_i (s3_g_q),
    .pix_o (green_c)
  );

  ycc_clamp #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SUM_W(SW)) u_clamp_b (
    .sum_i (s3_b_q),
    .pix_o (blue_c)
  );

  assign o_vs          = vs_dly_q[NUM_STAGES-1];
  assign o_hs          = hs_dly_q[NUM_STAGES-1];
  assign o_convert_en  = en_dly_q[NUM_STAGES-1];
  assign o_mode_active = mode_active_q;

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// Directed bench for ycbcr2rgb_pipe with hand-computed RGB values (DATA_W=8, FRAC_W=10).
module tb_ycbcr2rgb_pipe;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [1:0] i_mode = 2'b00;
  logic       i_vs = 1'b0;
  logic       i_hs = 1'b0;
  logic       i_convert_en = 1'b0;
  logic [7:0] i_y_data = 8'd0;
  logic [7:0] i_cb_data = 8'd0;
  logic [7:0] i_cr_data = 8'd0;
  logic       o_vs, o_hs, o_convert_en;
  logic [7:0] o_red, o_green, o_blue;
  logic [1:0] o_mode_active;

  int checks = 0;
  int errors = 0;
  int prev_r = 0;
  int prev_g = 0;
  int prev_b = 0;

  always #5 clk = ~clk;

  ycbcr2rgb_pipe #(.DATA_W(8), .FRAC_W(10)) dut (
    .i_sys_clk     (clk),
    .i_rst         (i_rst),
    .i_mode        (i_mode),
    .i_vs          (i_vs),
    .i_hs          (i_hs),
    .i_convert_en  (i_convert_en),
    .i_y_data      (i_y_data),
    .i_cb_data     (i_cb_data),
    .i_cr_data     (i_cr_data),
    .o_vs          (o_vs),
    .o_hs          (o_hs),
    .o_convert_en  (o_convert_en),
    .o_red         (o_red),
    .o_green       (o_green),
    .o_blue        (o_blue),
    .o_mode_active (o_mode_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_rgb(input string tag, input int er, input int eg, input int eb);
    chk({tag, ".r"}, 32'(o_red), er);
    chk({tag, ".g"}, 32'(o_green), eg);
    chk({tag, ".b"}, 32'(o_blue), eb);
  endtask

  task automatic drv(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                     input logic vs, input logic en);
    i_y_data     = y;
    i_cb_data    = cb;
    i_cr_data    = cr;
    i_vs         = vs;
    i_convert_en = en;
  endtask

  // One isolated pixel: checks hold/latency one cycle early, then the result 4 edges later.
  task automatic pix(input string tag, input logic [7:0] y, input logic [7:0] cb,
                     input logic [7:0] cr, input logic vs, input logic hs,
                     input int er, input int eg, input int eb);
    @(negedge clk);
    drv(y, cb, cr, vs, 1'b1);
    i_hs = hs;
    @(negedge clk);
    i_convert_en = 1'b0;
    i_hs         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, ".early_en"}, 32'(o_convert_en), 0);
    chk({tag, ".early_hs"}, 32'(o_hs), 0);
    chk_rgb({tag, ".hold"}, prev_r, prev_g, prev_b);
    @(negedge clk);
    chk({tag, ".en"}, 32'(o_convert_en), 1);
    chk({tag, ".hs"}, 32'(o_hs), 32'(hs));
    chk({tag, ".vs"}, 32'(o_vs), 32'(vs));
    chk_rgb(tag, er, eg, eb);
    prev_r = er;
    prev_g = eg;
    prev_b = eb;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_rgb("reset", 0, 0, 0);
    chk("reset.en", 32'(o_convert_en), 0);
    chk("reset.vs", 32'(o_vs), 0);
    chk("reset.hs", 32'(o_hs), 0);
    chk("reset.mode", 32'(o_mode_active), 0);

    // First pixel right after reset release; outputs stay quiet until it arrives.
    i_rst = 1'b0;
    drv(8'd128, 8'd128, 8'd128, 1'b1, 1'b1);
    i_hs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_convert_en = 1'b0;
      i_hs         = 1'b0;
      chk("postrst.en", 32'(o_convert_en), 0);
      chk("postrst.vs", 32'(o_vs), 0);
      chk("postrst.hs", 32'(o_hs), 0);
    end
    @(negedge clk);
    chk_rgb("grey601", 128, 128, 128);
    chk("grey601.en", 32'(o_convert_en), 1);
    chk("grey601.vs", 32'(o_vs), 1);
    chk("grey601.hs", 32'(o_hs), 1);
    chk("grey601.mode", 32'(o_mode_active), 0);
    prev_r = 128;
    prev_g = 128;
    prev_b = 128;

    // BT.601 full range, including both clamp directions
    pix("f601_hi", 8'd255, 8'd128, 8'd255, 1'b1, 1'b1, 255, 164, 255);
    pix("f601_lo", 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 0, 135, 0);
    pix("f601_mix", 8'd100, 8'd50, 8'd200, 1'b1, 1'b0, 201, 75, 0);

    // Mode change with vs held high has no effect
    i_mode = 2'b01;
    pix("nolatch", 8'd100, 8'd50, 8'd200, 1'b1, 1'b0, 201, 75, 0);
    chk("nolatch.mode", 32'(o_mode_active), 0);
    pix("vslow", 8'd128, 8'd128, 8'd128, 1'b0, 1'b0, 128, 128, 128);
    // The frame-start pixel itself uses BT.709
    pix("f709_rise", 8'd100, 8'd50, 8'd200, 1'b1, 1'b0, 213, 81, 0);
    chk("f709.mode", 32'(o_mode_active), 1);
    pix("f709_b", 8'd200, 8'd100, 8'd150, 1'b1, 1'b1, 235, 195, 148);

    // BT.601 limited range
    i_mode = 2'b10;
    pix("pre_l601", 8'd16, 8'd128, 8'd128, 1'b0, 1'b0, 16, 16, 16);
    pix("l601_blk", 8'd16, 8'd128, 8'd128, 1'b1, 1'b0, 0, 0, 0);
    chk("l601.mode", 32'(o_mode_active), 2);
    pix("l601_wht", 8'd235, 8'd128, 8'd128, 1'b1, 1'b0, 255, 255, 255);
    pix("l601_mix", 8'd100, 8'd50, 8'd200, 1'b1, 1'b0, 213, 70, 0);

    // BT.709 limited range
    i_mode = 2'b11;
    pix("pre_l709", 8'd200, 8'd100, 8'd150, 1'b0, 1'b0, 249, 207, 158);
    pix("l709_mix", 8'd200, 8'd100, 8'd150, 1'b1, 1'b0, 254, 208, 155);
    chk("l709.mode", 32'(o_mode_active), 3);

    // Back-to-back stream across a mode change, then a one-cycle reset mid-stream
    i_mode = 2'b00;
    @(negedge clk); drv(8'd200, 8'd100, 8'd150, 1'b0, 1'b1);
    @(negedge clk); drv(8'd100, 8'd50, 8'd200, 1'b1, 1'b1);
    @(negedge clk); drv(8'd255, 8'd128, 8'd255, 1'b1, 1'b1);
    @(negedge clk); drv(8'd128, 8'd128, 8'd128, 1'b1, 1'b1);
    @(negedge clk);
    chk_rgb("s0_oldmode", 254, 208, 155);
    chk("s0.en", 32'(o_convert_en), 1);
    drv(8'd200, 8'd100, 8'd150, 1'b1, 1'b1);
    @(negedge clk);
    chk_rgb("s1_newmode", 201, 75, 0);
    chk("s1.mode", 32'(o_mode_active), 0);
    drv(8'd100, 8'd50, 8'd200, 1'b1, 1'b1);
    i_rst = 1'b1;
    @(negedge clk);
    chk_rgb("midrst", 0, 0, 0);
    chk("midrst.en", 32'(o_convert_en), 0);
    chk("midrst.mode", 32'(o_mode_active), 0);
    i_rst = 1'b0;
    drv(8'd200, 8'd100, 8'd150, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush1.en", 32'(o_convert_en), 0);
    chk("flush1.vs", 32'(o_vs), 0);
    chk_rgb("flush1", 0, 0, 0);
    drv(8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush2.en", 32'(o_convert_en), 0);
    drv(8'd255, 8'd128, 8'd255, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush3.en", 32'(o_convert_en), 0);
    chk_rgb("flush3", 0, 0, 0);
    drv(8'd1, 8'd2, 8'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk_rgb("q0", 231, 194, 150);
    chk("q0.en", 32'(o_convert_en), 1);
    @(negedge clk);
    chk_rgb("q1", 0, 135, 0);
    @(negedge clk);
    chk_rgb("q2", 255, 164, 255);
    @(negedge clk);
    chk("idle.en", 32'(o_convert_en), 0);
    chk_rgb("idle_hold", 255, 164, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
